// File: rtl/debounce_multi.sv
// N-channel push-button conditioner: synchronizer, debounce filter, press/release
// pulses, long-press detection and optional auto-repeat for active-low keys.
module debounce_multi #(
    parameter int N_KEYS      = 4,
    parameter int DEB_CYCLES  = 12000,
    parameter int LONG_CYCLES = 6000000,
    parameter int REP_CYCLES  = 1200000,
    parameter int REPEAT_EN   = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [N_KEYS-1:0] i_in,
    output logic [N_KEYS-1:0] o_level,
    output logic [N_KEYS-1:0] o_neg,
    output logic [N_KEYS-1:0] o_pos,
    output logic [N_KEYS-1:0] o_long,
    output logic [N_KEYS-1:0] o_rep
);

    localparam int MAX_DL = (DEB_CYCLES > LONG_CYCLES) ? DEB_CYCLES : LONG_CYCLES;
    localparam int MAX_C  = (MAX_DL > REP_CYCLES) ? MAX_DL : REP_CYCLES;
    localparam int CW     = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] DEB_TERM  = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] LONG_TERM = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] REP_TERM  = CW'(REP_CYCLES - 1);
    localparam logic          REP_ON    = (REPEAT_EN != 0);

    typedef enum logic [1:0] {
        ST_REL   = 2'd0,
        ST_PRESS = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    for (genvar k = 0; k < N_KEYS; k++) begin : g_ch
        logic          s1_q;
        logic          s2_q;
        logic          stable_q;
        logic [CW-1:0] deb_cnt_q;
        logic [CW-1:0] deb_cnt_d;
        logic          flip_d;
        logic          press_evt_d;
        logic          release_evt_d;
        state_e        state_q;
        logic [CW-1:0] hold_cnt_q;
        logic          level_q;
        logic          neg_q;
        logic          pos_q;
        logic          long_q;
        logic          rep_q;

        // Debounce filter: count disagreeing samples, flip the stable level at the terminal count
        always_comb begin
            flip_d    = 1'b0;
            deb_cnt_d = deb_cnt_q;
            if (s2_q != stable_q) begin
                if (deb_cnt_q == DEB_TERM) begin
                    flip_d    = 1'b1;
                    deb_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + CW'(1);
                end
            end else begin
                deb_cnt_d = '0;
            end
            // stable_q holds the raw active-low level, so a flip from 1 is a press
            press_evt_d   = flip_d & stable_q;
            release_evt_d = flip_d & ~stable_q;
        end

        // Synchronizer, stable level and per-channel press/hold FSM with registered pulses
        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                s1_q       <= 1'b1;
                s2_q       <= 1'b1;
                stable_q   <= 1'b1;
                deb_cnt_q  <= '0;
                state_q    <= ST_REL;
                hold_cnt_q <= '0;
                level_q    <= 1'b0;
                neg_q      <= 1'b0;
                pos_q      <= 1'b0;
                long_q     <= 1'b0;
                rep_q      <= 1'b0;
            end else begin
                s1_q      <= i_in[k];
                s2_q      <= s1_q;
                deb_cnt_q <= deb_cnt_d;
                if (flip_d) begin
                    stable_q <= ~stable_q;
                end else begin
                    stable_q <= stable_q;
                end
                neg_q  <= 1'b0;
                pos_q  <= 1'b0;
                long_q <= 1'b0;
                rep_q  <= 1'b0;
                case (state_q)
                    ST_REL: begin
                        hold_cnt_q <= '0;
                        if (press_evt_d) begin
                            state_q <= ST_PRESS;
                            level_q <= 1'b1;
                            neg_q   <= 1'b1;
                        end else begin
                            level_q <= 1'b0;
                        end
                    end
                    ST_PRESS: begin
                        // Release takes priority over a coinciding long-press threshold
                        if (release_evt_d) begin
                            state_q    <= ST_REL;
                            level_q    <= 1'b0;
                            pos_q      <= 1'b1;
                            hold_cnt_q <= '0;
                        end else if (hold_cnt_q == LONG_TERM) begin
                            state_q    <= ST_HOLD;
                            long_q     <= 1'b1;
                            hold_cnt_q <= '0;
                        end else begin
                            hold_cnt_q <= hold_cnt_q + CW'(1);
                        end
                    end
                    ST_HOLD: begin
                        if (release_evt_d) begin
                            state_q    <= ST_REL;
                            level_q    <= 1'b0;
                            pos_q      <= 1'b1;
                            hold_cnt_q <= '0;
                        end else if (hold_cnt_q == REP_TERM) begin
                            rep_q      <= REP_ON;
                            hold_cnt_q <= '0;
                        end else begin
                            hold_cnt_q <= hold_cnt_q + CW'(1);
                        end
                    end
                    default: begin
                        state_q    <= ST_REL;
                        level_q    <= 1'b0;
                        hold_cnt_q <= '0;
                    end
                endcase
            end
        end

        assign o_level[k] = level_q;
        assign o_neg[k]   = neg_q;
        assign o_pos[k]   = pos_q;
        assign o_long[k]  = long_q;
        assign o_rep[k]   = rep_q;
    end

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
- Parametrised N-channel push-button conditioner; successor to the single-channel press-edge debouncer.
- Per channel: 2-FF synchronizer, debounce filter, press/release pulses, long-press detection and optional auto-repeat.
- Sits between the active-low board keys and the top controller in the 12 MHz audio clock domain.
- One instance replaces the per-key debouncer instances.

Parameters:
N_KEYS, 4, number of independent channels
DEB_CYCLES, 12000, consecutive stable samples needed to accept a level change (1 ms at 12 MHz)
LONG_CYCLES, 6000000, held-pressed cycles before o_long fires (0.5 s)
REP_CYCLES, 1200000, auto-repeat period after long press (0.1 s)
REPEAT_EN, 1, 1 enables o_rep generation; 0 ties o_rep low

Ports:
i_clk  input  1  system clock (12 MHz)
i_rst_n  input  1  synchronous active-low reset
i_in  input  N_KEYS  raw keys, active-low (0 = pressed), asynchronous to i_clk
o_level  output  N_KEYS  debounced state, active-high (1 = pressed)
o_neg  output  N_KEYS  1-cycle pulse on accepted press (debounced falling edge of i_in)
o_pos  output  N_KEYS  1-cycle pulse on accepted release
o_long  output  N_KEYS  1-cycle pulse when a press has been held LONG_CYCLES
o_rep  output  N_KEYS  1-cycle pulse every REP_CYCLES after o_long while still held

Behaviour:
- Reset (i_rst_n=0 at a rising edge):
  - sync FFs = 1; stable state = released.
  - Debounce and hold counters = 0; FSM = REL.
  - All outputs = 0.
- Channels are fully independent; simultaneous events on different channels are all reported in the same cycle.
- Synchronizer: s1 <= i_in[k]; s2 <= s1.
- Debounce counter:
  - Counts while s2 differs from the stable level; clears to 0 the cycle s2 equals it.
  - When the counter is at DEB_CYCLES-1 and s2 still differs, the stable level flips and the counter clears.
  - Any glitch shorter than DEB_CYCLES cycles produces no output.
- Latency: a new i_in level first captured in s1 at edge E gives the stable flip, with the o_level change and pulse, visible after edge E+DEB_CYCLES+1. All outputs are registered.
- FSM per channel, states REL, PRESS, HOLD:
  - REL -> PRESS on stable press: o_neg=1 for one cycle; hold counter cleared.
  - PRESS: hold counter increments each cycle.
    - At count LONG_CYCLES-1: o_long=1 for one cycle; -> HOLD; counter cleared.
  - HOLD: counter increments.
    - At REP_CYCLES-1: o_rep=1 (only if REPEAT_EN) and counter clears, i.e. wraps.
  - PRESS or HOLD -> REL on stable release: o_pos=1 for one cycle; hold counter cleared; no o_long/o_rep that cycle.
  - If release and the long/repeat threshold coincide, release wins: o_pos only.
- Counter widths are $clog2(max(DEB_CYCLES,LONG_CYCLES,REP_CYCLES)+1). Counters never exceed their terminal value.
- o_level = 1 in PRESS and HOLD.
- Mid-operation reset: all outputs drop and the FSM returns to REL. A key still held after reset deasserts is reported as a new press (o_neg) after the normal debounce latency.
- At most one of o_neg/o_pos/o_long/o_rep is high per channel per cycle.

Test Plan:
(Bench parameters: N_KEYS=4, DEB_CYCLES=4, LONG_CYCLES=20, REP_CYCLES=8.)
- Reset then idle: i_in=4'b1111 for 50 cycles -> all outputs stay 0.
- Clean press on key0: i_in[0]=0 captured at edge E -> o_neg[0]=1 after edge E+5 only (1 cycle), o_level[0]=1 from then. Release -> o_pos[0] after 5 edges.
- Glitches: i_in[1] low for 3 cycles, high 1, low 3 -> no o_neg[1]; counter clears on the high sample.
- Long press with repeat: hold key2 for 60 cycles after o_neg -> o_long at +20 cycles, o_rep at +28, +36, +44, +52. Release -> o_pos, no further o_rep. Rerun with REPEAT_EN=0 -> o_long only.
- Simultaneous and boundary cases:
  - Keys 0 and 3 pressed on the same edge -> both o_neg in the same cycle.
  - Release timed so the stable release lands on the o_long threshold cycle -> o_pos=1, o_long=0.
- Reset mid-hold: assert i_rst_n=0 for 1 cycle while key1 is in HOLD and still pressed -> outputs 0 next cycle. o_neg[1] is re-reported 6 edges after reset release.
